// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the buzzer tone sequencer.
// Holds the FSM state encoding, default field widths and the ms divider helper.
package tone_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_DIV_W = 18;
  localparam int DEFAULT_DUR_W = 12;

  // Clock cycles per millisecond; integer division truncates odd clock rates.
  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_DIV-1 and flags the last count as tick.
// clr restarts the count so every state begins on a full millisecond.
module ms_tick_gen #(
  parameter int unsigned MS_DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == CW'(MS_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/buzzer_tone_seq.sv
// Buzzer note sequencer: accepts (divisor, duration) commands and plays a square wave.
// Define TONE_SEQ_GAP_EN to insert GAP_MS of silence after every note.
module buzzer_tone_seq
  import tone_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          DIV_W  = DEFAULT_DIV_W,
  parameter int          DUR_W  = DEFAULT_DUR_W,
  parameter int unsigned GAP_MS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic             sound,
  output logic             busy,
  output logic             note_done
);

  localparam int unsigned MS_DIV = ms_div(CLK_HZ);
  localparam int          GAP_W  = 16;
`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP_ON = (GAP_MS != 0);
`else
  localparam bit GAP_ON = 1'b0;
`endif

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] hp_cnt_reg;
  logic [DUR_W-1:0] rem_reg;
  logic [GAP_W-1:0] gap_rem_reg;
  logic             sound_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;

  logic ms_tick;
  logic ms_clr;
  logic accept;
  logic note_end;
  logic gap_end;

  // abort masks ready combinationally so a simultaneous command is never taken.
  assign cmd_ready = ready_reg & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign note_end  = (state_reg == PLAY) & ms_tick & (rem_reg == DUR_W'(1));
  assign gap_end   = (state_reg == GAP) & ms_tick & (gap_rem_reg == GAP_W'(1));

  // Holding the prescaler clear in IDLE and on every exit edge means each
  // PLAY/GAP entry starts from a fresh millisecond.
  assign ms_clr = abort | (state_reg == IDLE) | note_end | gap_end;

  assign sound     = sound_reg;
  assign busy      = busy_reg;
  assign note_done = done_reg;

  ms_tick_gen #(
    .MS_DIV (MS_DIV)
  ) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ms_clr),
    .tick  (ms_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      hp_cnt_reg  <= '0;
      rem_reg     <= '0;
      gap_rem_reg <= '0;
      sound_reg   <= 1'b0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg   <= IDLE;
        div_reg     <= '0;
        hp_cnt_reg  <= '0;
        rem_reg     <= '0;
        gap_rem_reg <= '0;
        sound_reg   <= 1'b0;
        ready_reg   <= 1'b1;
        busy_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              div_reg    <= cmd_div;
              rem_reg    <= cmd_dur;
              hp_cnt_reg <= '0;
              sound_reg  <= 1'b0;
              if (cmd_dur == '0) begin
                done_reg <= 1'b1;
              end else begin
                state_reg <= PLAY;
                ready_reg <= 1'b0;
                busy_reg  <= 1'b1;
              end
            end
          end

          PLAY: begin
            if (note_end) begin
              sound_reg  <= 1'b0;
              done_reg   <= 1'b1;
              hp_cnt_reg <= '0;
              rem_reg    <= '0;
              if (GAP_ON) begin
                state_reg   <= GAP;
                gap_rem_reg <= GAP_W'(GAP_MS);
              end else begin
                state_reg <= IDLE;
                ready_reg <= 1'b1;
                busy_reg  <= 1'b0;
              end
            end else begin
              if (ms_tick) begin
                rem_reg <= rem_reg - DUR_W'(1);
              end
              // A zero divisor is a rest: the counter idles and the pin stays low.
              if (div_reg == '0) begin
                hp_cnt_reg <= '0;
                sound_reg  <= 1'b0;
              end else if (hp_cnt_reg == div_reg - DIV_W'(1)) begin
                hp_cnt_reg <= '0;
                sound_reg  <= ~sound_reg;
              end else begin
                hp_cnt_reg <= hp_cnt_reg + DIV_W'(1);
              end
            end
          end

          GAP: begin
            sound_reg <= 1'b0;
            if (gap_end) begin
              state_reg   <= IDLE;
              gap_rem_reg <= '0;
              ready_reg   <= 1'b1;
              busy_reg    <= 1'b0;
            end else if (ms_tick) begin
              gap_rem_reg <= gap_rem_reg - GAP_W'(1);
            end
          end

          default: begin
            state_reg <= IDLE;
            sound_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Directed bench for buzzer_tone_seq at CLK_HZ=10_000 (10 cycles per ms).
// Cycle N is the handshake cycle; outputs are sampled 1 ns after each rising edge.
module tb_buzzer_tone_seq;

  localparam int unsigned CLK_HZ = 10_000;
  localparam int          DIV_W  = 18;
  localparam int          DUR_W  = 12;
  localparam int unsigned GAP_MS = 2;
`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             abort     = 1'b0;
  logic [DIV_W-1:0] cmd_div   = '0;
  logic [DUR_W-1:0] cmd_dur   = '0;
  logic             cmd_ready;
  logic             sound;
  logic             busy;
  logic             note_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  buzzer_tone_seq #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W),
    .DUR_W  (DUR_W),
    .GAP_MS (GAP_MS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_div   (cmd_div),
    .cmd_dur   (cmd_dur),
    .abort     (abort),
    .sound     (sound),
    .busy      (busy),
    .note_done (note_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && cmd_ready === 1'b1) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b cmd_ready=%b required busy=0 cmd_ready=1", busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({sound, cmd_ready, busy, note_done} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_state got={sound,ready,busy,done}=%b required=0100", {sound, cmd_ready, busy, note_done});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({sound, cmd_ready, busy, note_done} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_release got=%b required=0100", {sound, cmd_ready, busy, note_done});
    end
    // Note div=3 dur=5; at N+18 the wave is in its high half.
    cmd_div = 18'd3; cmd_dur = 12'd5; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (17) step();
    checks++;
    if ({sound, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre_sound got={sound,busy}=%b required=11", {sound, busy});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({sound, cmd_ready, busy, note_done} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_async got=%b required=0100", {sound, cmd_ready, busy, note_done});
    end
    step();
    step();
    checks++;
    if ({sound, cmd_ready, busy, note_done} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_hold got=%b required=0100", {sound, cmd_ready, busy, note_done});
    end
    rst_n = 1'b1;
    step();
    $display("reset: mid-note reset div=3 dur=5 cleared outputs");
  endtask

  task automatic test_basic_note();
    logic [3:0] exp;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_before got=%b required=1", cmd_ready);
    end
    cmd_div = 18'd3; cmd_dur = 12'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k <= 20)      exp = {1'(((k - 1) / 3) % 2), 1'b1, 1'b0, 1'b0};
      else if (k == 21) exp = {1'b0, GAP_ON, !GAP_ON, 1'b1};
      else              exp = {1'b0, GAP_ON, !GAP_ON, 1'b0};
      checks++;
      if ({sound, busy, cmd_ready, note_done} !== exp) begin
        errors++;
        $display("FAIL basic_note cycle=N+%0d got={sound,busy,ready,done}=%b required=%b", k, {sound, busy, cmd_ready, note_done}, exp);
      end
      step();
    end
    wait_idle();
    $display("basic: note div=3 dur=2 played 20 cycles");
  endtask

  task automatic test_rest_and_zero();
    logic [3:0] exp;
    cmd_div = 18'd0; cmd_dur = 12'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k <= 30)      exp = 4'b0100;
      else if (k == 31) exp = {1'b0, GAP_ON, !GAP_ON, 1'b1};
      else              exp = {1'b0, GAP_ON, !GAP_ON, 1'b0};
      checks++;
      if ({sound, busy, cmd_ready, note_done} !== exp) begin
        errors++;
        $display("FAIL rest_note cycle=N+%0d got={sound,busy,ready,done}=%b required=%b", k, {sound, busy, cmd_ready, note_done}, exp);
      end
      step();
    end
    wait_idle();
    $display("rest: note div=0 dur=3 silent for 30 cycles");
    cmd_div = 18'd5; cmd_dur = 12'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({sound, busy, cmd_ready, note_done} !== 4'b0011) begin
      errors++;
      $display("FAIL zero_dur_done got={sound,busy,ready,done}=%b required=0011", {sound, busy, cmd_ready, note_done});
    end
    step();
    checks++;
    if ({sound, busy, cmd_ready, note_done} !== 4'b0010) begin
      errors++;
      $display("FAIL zero_dur_after got={sound,busy,ready,done}=%b required=0010", {sound, busy, cmd_ready, note_done});
    end
    $display("zero: note div=5 dur=0 done without busy");
  endtask

  task automatic test_abort();
    logic [3:0] exp;
    cmd_div = 18'd2; cmd_dur = 12'd4; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      exp = {1'(((k - 1) / 2) % 2), 1'b1, 1'b0, 1'b0};
      checks++;
      if ({sound, busy, cmd_ready, note_done} !== exp) begin
        errors++;
        $display("FAIL abort_play cycle=N+%0d got={sound,busy,ready,done}=%b required=%b", k, {sound, busy, cmd_ready, note_done}, exp);
      end
      if (k < 15) step();
    end
    abort = 1'b1;
    step();
    checks++;
    if ({sound, busy, cmd_ready, note_done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle got={sound,busy,ready,done}=%b required=0000", {sound, busy, cmd_ready, note_done});
    end
    abort = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_release_ready got=%b required=1", cmd_ready);
    end
    for (int k = 0; k < 25; k++) begin
      step();
      checks++;
      if ({busy, note_done} !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_done cycle=%0d got={busy,done}=%b required=00", k, {busy, note_done});
      end
    end
    abort = 1'b1; cmd_valid = 1'b1; cmd_div = 18'd3; cmd_dur = 12'd2;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_masks_ready got=%b required=0", cmd_ready);
    end
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    #1;
    checks++;
    if ({busy, note_done, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL abort_no_accept got={busy,done,ready}=%b required=001", {busy, note_done, cmd_ready});
    end
    $display("abort: note div=2 dur=4 aborted at N+15, abort+valid rejected");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int n;
    wait_idle();
    cmd_div = 18'd1; cmd_dur = 12'd1; cmd_valid = 1'b1;
    step();
    cmd_div = 18'd2;
    for (int k = 1; k <= 10; k++) begin
      exp = {1'((k - 1) % 2), 1'b1, 1'b0, 1'b0};
      checks++;
      if ({sound, busy, cmd_ready, note_done} !== exp) begin
        errors++;
        $display("FAIL b2b_first cycle=N+%0d got={sound,busy,ready,done}=%b required=%b", k, {sound, busy, cmd_ready, note_done}, exp);
      end
      step();
    end
    checks++;
    if ({sound, note_done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first_done got={sound,done}=%b required=01", {sound, note_done});
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== (GAP_ON ? 20 : 0)) begin
      errors++;
      $display("FAIL b2b_ready_wait got=%0d cycles required=%0d", n, (GAP_ON ? 20 : 0));
    end
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 10) exp = {1'(((k - 1) / 2) % 2), 1'b1, 1'b0, 1'b0};
      else         exp = {1'b0, GAP_ON, !GAP_ON, 1'b1};
      checks++;
      if ({sound, busy, cmd_ready, note_done} !== exp) begin
        errors++;
        $display("FAIL b2b_second cycle=M+%0d got={sound,busy,ready,done}=%b required=%b", k, {sound, busy, cmd_ready, note_done}, exp);
      end
      step();
    end
    wait_idle();
    $display("b2b: held second command div=2 dur=1 accepted on first idle cycle");
  endtask

`ifdef TONE_SEQ_GAP_EN
  task automatic test_gap();
    wait_idle();
    cmd_div = 18'd2; cmd_dur = 12'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (10) step();
    for (int k = 11; k <= 30; k++) begin
      checks++;
      if ({busy, cmd_ready, sound} !== 3'b100) begin
        errors++;
        $display("FAIL gap_hold cycle=N+%0d got={busy,ready,sound}=%b required=100", k, {busy, cmd_ready, sound});
      end
      step();
    end
    checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL gap_exit got={busy,ready}=%b required=01", {busy, cmd_ready});
    end
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (15) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    checks++;
    if ({busy, cmd_ready, sound, note_done} !== 4'b0100) begin
      errors++;
      $display("FAIL gap_abort got={busy,ready,sound,done}=%b required=0100", {busy, cmd_ready, sound, note_done});
    end
    $display("gap: 20-cycle gap after note, abort in gap returns to idle");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_note();
    test_rest_and_zero();
    test_abort();
    test_back_to_back();
`ifdef TONE_SEQ_GAP_EN
    test_gap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
